or_word_splitter_8bit: RTL and testbench

Sequential inverse of the 8-bit OR combiner. Accepts one 8-bit word via a valid/accept handshake and emits its set bits one per beat as one-hot 8-bit words, so the OR of all beats of a word reproduces the input word. Sits upstream of per-bit consumers such as interrupt/request dispatch, or downstream of or_gate_8bit merge trees.

---
 rtl/or_word_splitter_8bit.sv | 175 +++++++++++++++++
 tb/tb_or_word_splitter_8bit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/or_word_splitter_8bit.sv
// ----------------------------------------------------------------------------
// or_word_splitter_8bit
// Takes one 8-bit word through a valid/accept handshake and replays its set
// bits one per beat as one-hot words; the OR of a word's beats equals the word.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   inWord     word to split
//   inValid    inWord is valid
//   outAccept  splitter can take a word (IDLE only)
//   outBit     current one-hot beat (8'h00 for a zero-word beat)
//   outIndex   bit position of outBit
//   outValid   beat is valid
//   outLast    final beat of the current word
//   inReady    downstream consumes the beat this cycle
//   outRemain  bits of the current word not yet consumed, incl. current beat
//
// Parameter ZERO_EMIT: 1 = zero word yields one empty last beat, 0 = dropped.
// Macro SPLIT_MSB_FIRST_EN: when defined, beats go highest set bit first.
// ----------------------------------------------------------------------------
module or_word_splitter_8bit #(
    parameter int unsigned ZERO_EMIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] inWord,
    input  logic       inValid,
    output logic       outAccept,
    output logic [7:0] outBit,
    output logic [2:0] outIndex,
    output logic       outValid,
    output logic       outLast,
    input  logic       inReady,
    output logic [7:0] outRemain
);

    localparam int unsigned W  = 8;
    localparam int unsigned IW = 3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Select the bit emitted next from the pending set.
    function automatic logic [W-1:0] pick_bit(input logic [W-1:0] r);
        logic [W-1:0] b;
        b = '0;
`ifdef SPLIT_MSB_FIRST_EN
        for (int i = 0; i < int'(W); i++) begin
            if (r[i]) b = W'(1) << i;
        end
`else
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (r[i]) b = W'(1) << i;
        end
`endif
        return b;
    endfunction

    // Position of the bit pick_bit selects (0 when nothing is pending).
    function automatic logic [IW-1:0] pick_idx(input logic [W-1:0] r);
        logic [IW-1:0] idx;
        idx = '0;
`ifdef SPLIT_MSB_FIRST_EN
        for (int i = 0; i < int'(W); i++) begin
            if (r[i]) idx = IW'(i);
        end
`else
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (r[i]) idx = IW'(i);
        end
`endif
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [W-1:0] r);
        return (r != '0) && ((r & (r - W'(1))) == '0);
    endfunction

    state_t        state_q, state_d;
    logic [W-1:0]  remain_q, remain_d;
    logic          zero_q, zero_d;

    logic          accept_q, accept_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic [W-1:0]  bit_q, bit_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  rem_out_q, rem_out_d;

    // Next state, plus the outputs decoded from that next state so they can
    // be registered and still track the state exactly.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (inValid) begin
                    if (inWord != '0) begin
                        remain_d = inWord;
                        state_d  = EMIT;
                    end else if (ZERO_EMIT != 0) begin
                        remain_d = '0;
                        zero_d   = 1'b1;
                        state_d  = EMIT;
                    end
                end
            end
            EMIT: begin
                // bit_q/last_q always describe the beat on the outputs
                if (inReady) begin
                    remain_d = remain_q & ~bit_q;
                    if (last_q) begin
                        state_d = IDLE;
                        zero_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                remain_d = '0;
                zero_d   = 1'b0;
            end
        endcase

        accept_d  = (state_d == IDLE);
        valid_d   = (state_d == EMIT);
        bit_d     = '0;
        idx_d     = '0;
        last_d    = 1'b0;
        rem_out_d = remain_d;
        if (state_d == EMIT) begin
            bit_d  = pick_bit(remain_d);
            idx_d  = pick_idx(remain_d);
            last_d = zero_d || is_onehot(remain_d);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            remain_q  <= '0;
            zero_q    <= 1'b0;
            accept_q  <= 1'b1;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            bit_q     <= '0;
            idx_q     <= '0;
            rem_out_q <= '0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            zero_q    <= zero_d;
            accept_q  <= accept_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            rem_out_q <= rem_out_d;
        end
    end

    assign outAccept = accept_q;
    assign outValid  = valid_q;
    assign outLast   = last_q;
    assign outBit    = bit_q;
    assign outIndex  = idx_q;
    assign outRemain = rem_out_q;

endmodule

// File: tb/tb_or_word_splitter_8bit.sv
// ----------------------------------------------------------------------------
// tb_or_word_splitter_8bit
// Directed bench for or_word_splitter_8bit. dut uses ZERO_EMIT=1, dut_nz uses
// ZERO_EMIT=0; both see the same stimulus. Observed outputs are packed as
// {outValid, outAccept, outLast, outIndex, outBit, outRemain}.
// ----------------------------------------------------------------------------
module tb_or_word_splitter_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] inWord;
    logic       inValid;
    logic       inReady;

    logic       outAccept, outValid, outLast;
    logic [7:0] outBit, outRemain;
    logic [2:0] outIndex;

    logic       nz_accept, nz_valid, nz_last;
    logic [7:0] nz_bit, nz_remain;
    logic [2:0] nz_index;

    int checks = 0;
    int errors = 0;

    logic [21:0] obs, obs_nz;
    assign obs    = {outValid, outAccept, outLast, outIndex, outBit, outRemain};
    assign obs_nz = {nz_valid, nz_accept, nz_last, nz_index, nz_bit, nz_remain};

    localparam logic [21:0] IDLE_OBS = {1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00};

    or_word_splitter_8bit #(.ZERO_EMIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .inWord(inWord), .inValid(inValid),
        .outAccept(outAccept), .outBit(outBit), .outIndex(outIndex),
        .outValid(outValid), .outLast(outLast), .inReady(inReady),
        .outRemain(outRemain)
    );

    or_word_splitter_8bit #(.ZERO_EMIT(0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .inWord(inWord), .inValid(inValid),
        .outAccept(nz_accept), .outBit(nz_bit), .outIndex(nz_index),
        .outValid(nz_valid), .outLast(nz_last), .inReady(inReady),
        .outRemain(nz_remain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] beat(input logic last, input logic [2:0] idx,
                                         input logic [7:0] b, input logic [7:0] rem);
        return {1'b1, 1'b0, last, idx, b, rem};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; inWord = 8'h00; inValid = 1'b0; inReady = 1'b0;
        step(); step();
        checks++;
        if (obs !== IDLE_OBS) begin
            errors++;
            $display("FAIL reset_state: got %h exp %h", obs, IDLE_OBS);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (obs !== IDLE_OBS) begin
                errors++;
                $display("FAIL idle_hold cyc %0d: got %h exp %h", c, obs, IDLE_OBS);
            end
        end
    endtask

    task automatic test_word_a5();
        logic [21:0] exp [4];
`ifdef SPLIT_MSB_FIRST_EN
        exp[0] = beat(1'b0, 3'd7, 8'h80, 8'hA5);
        exp[1] = beat(1'b0, 3'd5, 8'h20, 8'h25);
        exp[2] = beat(1'b0, 3'd2, 8'h04, 8'h05);
        exp[3] = beat(1'b1, 3'd0, 8'h01, 8'h01);
`else
        exp[0] = beat(1'b0, 3'd0, 8'h01, 8'hA5);
        exp[1] = beat(1'b0, 3'd2, 8'h04, 8'hA4);
        exp[2] = beat(1'b0, 3'd5, 8'h20, 8'hA0);
        exp[3] = beat(1'b1, 3'd7, 8'h80, 8'h80);
`endif
        inWord = 8'hA5; inValid = 1'b1; inReady = 1'b1;
        step();
        inValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL a5_beat %0d: got %h exp %h", i, obs, exp[i]);
            end
            step();
        end
        checks++;
        if (obs !== IDLE_OBS) begin
            errors++;
            $display("FAIL a5_after: got %h exp %h", obs, IDLE_OBS);
        end
    endtask

    task automatic test_stall();
        logic        rdy [5];
        logic [21:0] exp [5];
        rdy[0] = 1'b0; rdy[1] = 1'b1; rdy[2] = 1'b0; rdy[3] = 1'b0; rdy[4] = 1'b1;
`ifdef SPLIT_MSB_FIRST_EN
        exp[0] = beat(1'b0, 3'd4, 8'h10, 8'h12);
        exp[1] = exp[0];
        exp[2] = beat(1'b1, 3'd1, 8'h02, 8'h02);
`else
        exp[0] = beat(1'b0, 3'd1, 8'h02, 8'h12);
        exp[1] = exp[0];
        exp[2] = beat(1'b1, 3'd4, 8'h10, 8'h10);
`endif
        exp[3] = exp[2];
        exp[4] = exp[2];
        inWord = 8'h12; inValid = 1'b1; inReady = 1'b0;
        step();
        inValid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            inReady = rdy[k];
            checks++;
            if (obs !== exp[k]) begin
                errors++;
                $display("FAIL stall_cyc %0d: got %h exp %h", k, obs, exp[k]);
            end
            step();
        end
        checks++;
        if (obs !== IDLE_OBS) begin
            errors++;
            $display("FAIL stall_after: got %h exp %h", obs, IDLE_OBS);
        end
    endtask

    task automatic test_zero_word();
        inWord = 8'h00; inValid = 1'b1; inReady = 1'b1;
        step();
        inValid = 1'b0;
        checks++;
        if (obs !== beat(1'b1, 3'd0, 8'h00, 8'h00)) begin
            errors++;
            $display("FAIL zero_emit_beat: got %h exp %h", obs, beat(1'b1, 3'd0, 8'h00, 8'h00));
        end
        checks++;
        if (obs_nz !== IDLE_OBS) begin
            errors++;
            $display("FAIL zero_drop: got %h exp %h", obs_nz, IDLE_OBS);
        end
        step();
        checks++;
        if (obs !== IDLE_OBS) begin
            errors++;
            $display("FAIL zero_after: got %h exp %h", obs, IDLE_OBS);
        end
        checks++;
        if (obs_nz !== IDLE_OBS) begin
            errors++;
            $display("FAIL zero_drop_after: got %h exp %h", obs_nz, IDLE_OBS);
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] exp [5];
`ifdef SPLIT_MSB_FIRST_EN
        exp[0] = beat(1'b0, 3'd1, 8'h02, 8'h03);
        exp[1] = beat(1'b1, 3'd0, 8'h01, 8'h01);
`else
        exp[0] = beat(1'b0, 3'd0, 8'h01, 8'h03);
        exp[1] = beat(1'b1, 3'd1, 8'h02, 8'h02);
`endif
        exp[2] = IDLE_OBS;
        exp[3] = beat(1'b1, 3'd6, 8'h40, 8'h40);
        exp[4] = IDLE_OBS;
        inWord = 8'h03; inValid = 1'b1; inReady = 1'b1;
        step();
        // next word presented immediately; ignored until outAccept returns
        inWord = 8'h40;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) inValid = 1'b0;
            checks++;
            if (obs !== exp[k]) begin
                errors++;
                $display("FAIL b2b_cyc %0d: got %h exp %h", k, obs, exp[k]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [21:0] exp [3];
`ifdef SPLIT_MSB_FIRST_EN
        exp[0] = beat(1'b0, 3'd7, 8'h80, 8'hF0);
        exp[1] = beat(1'b0, 3'd6, 8'h40, 8'h70);
        exp[2] = beat(1'b0, 3'd5, 8'h20, 8'h30);
`else
        exp[0] = beat(1'b0, 3'd4, 8'h10, 8'hF0);
        exp[1] = beat(1'b0, 3'd5, 8'h20, 8'hE0);
        exp[2] = beat(1'b0, 3'd6, 8'h40, 8'hC0);
`endif
        inWord = 8'hF0; inValid = 1'b1; inReady = 1'b1;
        step();
        inValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) rst_n = 1'b0;
            checks++;
            if (obs !== exp[k]) begin
                errors++;
                $display("FAIL rstmid_beat %0d: got %h exp %h", k, obs, exp[k]);
            end
            step();
        end
        checks++;
        if (obs !== IDLE_OBS) begin
            errors++;
            $display("FAIL rstmid_after: got %h exp %h", obs, IDLE_OBS);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (obs !== IDLE_OBS) begin
            errors++;
            $display("FAIL rstmid_release: got %h exp %h", obs, IDLE_OBS);
        end
    endtask

    task automatic test_word_ff();
        logic [7:0] rem;
        logic [7:0] acc;
        rem = 8'hFF;
        acc = 8'h00;
        inWord = 8'hFF; inValid = 1'b1; inReady = 1'b1;
        step();
        inValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0]  ix;
            logic [7:0]  b;
            logic [21:0] e;
`ifdef SPLIT_MSB_FIRST_EN
            ix = 3'(7 - i);
`else
            ix = 3'(i);
`endif
            b = 8'h01 << ix;
            e = beat(i == 7, ix, b, rem);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL ff_beat %0d: got %h exp %h", i, obs, e);
            end
            acc = acc | outBit;
            rem = rem & ~b;
            step();
        end
        checks++;
        if (acc !== 8'hFF) begin
            errors++;
            $display("FAIL ff_or: got %h exp ff", acc);
        end
        checks++;
        if (obs !== IDLE_OBS) begin
            errors++;
            $display("FAIL ff_after: got %h exp %h", obs, IDLE_OBS);
        end
    endtask

    task automatic test_word_80();
        inWord = 8'h80; inValid = 1'b1; inReady = 1'b1;
        step();
        inValid = 1'b0;
        checks++;
        if (obs !== beat(1'b1, 3'd7, 8'h80, 8'h80)) begin
            errors++;
            $display("FAIL w80_beat: got %h exp %h", obs, beat(1'b1, 3'd7, 8'h80, 8'h80));
        end
        step();
        checks++;
        if (obs !== IDLE_OBS) begin
            errors++;
            $display("FAIL w80_after: got %h exp %h", obs, IDLE_OBS);
        end
    endtask

    initial begin
        test_reset();
        test_word_a5();
        test_stall();
        test_zero_word();
        test_back_to_back();
        test_reset_mid();
        test_word_ff();
        test_word_80();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
